stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//  N-channel, W-bit registered stream multiplexer with valid/ready handshake on every port.
//  Next generation of the 4:1 select mux.
//  Two selection modes:
//  - round-robin arbitration across requesting channels
//  - fixed select from an external sel input
//  One output register stage. Sits between parallel producers and a single shared consumer.
// PARAMETERS
//  N_CH   4  number of input channels, >=2, need not be a power of two
//  WIDTH  8  data width per channel, >=1
//  SEL_W  $clog2(N_CH)  derived (localparam), width of sel and out_ch
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous active-low reset
//  mode       in   1            0 = round-robin, 1 = fixed select
//  sel        in   SEL_W        channel index used when mode=1
//  in_valid   in   N_CH         per-channel valid
//  in_ready   out  N_CH         per-channel ready; at most one bit high
//  in_data    in   N_CH*WIDTH   channel i at [i*WIDTH +: WIDTH]
//  out_valid  out  1            output holds a word
//  out_ready  in   1            consumer accepts the word
//  out_data   out  WIDTH        registered data
//  out_ch     out  SEL_W        source channel of out_data
// BEHAVIOUR
//  - Reset (async assert, sync-safe release):
//    - out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
//    - in_ready is all 0 while rst_n=0.
//  - load_en = !out_valid | out_ready.
//    - Output register accepts a new word only when load_en=1.
//  - Grant (combinational, one-hot or zero):
//    - mode=0: first i with in_valid[i]=1, searched from ptr upward with wrap N_CH-1 -> 0.
//    - mode=1: grant[sel] = in_valid[sel]. If sel >= N_CH, no grant.
//  - in_ready[i] = grant[i] & load_en. Transfer on channel i when in_valid[i] & in_ready[i].
//  - On transfer (next clk edge): out_data <= channel data; out_ch <= i; out_valid <= 1.
//  - If load_en=1 and no grant: out_valid <= 0 and out_data/out_ch hold their old values.
//  - Latency 1 cycle input->output. Sustained throughput 1 word/cycle when out_ready=1.
//  - Backpressure: while out_valid=1 & out_ready=0, out_data/out_ch/out_valid are held stable.
//  - Round-robin pointer:
//    - Updates only on a transfer in mode=0: ptr <= (i==N_CH-1) ? 0 : i+1.
//    - Unchanged in mode=1 and on idle cycles.
//  - Mode or sel change:
//    - Takes effect on the same-cycle grant.
//    - Never alters a word already held in the output register.
//  - Input protocol: producers keep data stable while valid & !ready. Block does not check this.
//  - Simultaneous drain and load (out_valid=1, out_ready=1, grant present): new word loaded, no bubble.
//  - Reset mid-operation: held word is discarded; restarts from ptr=0.
// TESTING
//  1. Reset: rst_n=0 with all in_valid=1
//     -> out_valid=0, out_data=0, in_ready=0000.
//     Release, out_ready=1 -> first word from ch0 one cycle later.
//  2. RR fairness: N_CH=4, all in_valid=1 constantly, out_ready=1, data = 8'hA0+ch
//     -> out_ch sequence 0,1,2,3,0,...; out_data A0,A1,A2,A3,A0.
//  3. RR skip/wrap: only ch1 and ch3 valid, ptr=2
//     -> grant ch3, then ch1, then ch3.
//     Idle channels never get in_ready.
//  4. Fixed mode: mode=1, sel=2, all valid
//     -> only in_ready[2] toggles; out_ch=2 every cycle; ptr unchanged.
//     sel=3 with in_valid[3]=0 -> out_valid drops to 0 next cycle.
//  5. Backpressure: out_ready=0 for 3 cycles with out_valid=1
//     -> out_data stable and in_ready=0000.
//     out_ready=1 -> next word loads same cycle, no bubble.
//  6. Async reset mid-stream: assert rst_n low between edges
//     -> out_valid=0 immediately.
//     After release, arbitration restarts at ch0.

Source files
------------

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N_CH producer streams in, one registered stream out.
// The master modport is the mux; the slave modport is the producers and consumer around it.
interface stream_mux_rr_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [N_CH*WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with round-robin or fixed-select arbitration.
// One output register stage; a new word loads whenever the register is empty or draining.
module stream_mux_rr #(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode_i,
    input  logic [SEL_W-1:0]   sel_i,
    stream_mux_rr_if.master    bus
);

    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [N_CH-1:0]  ready;
    logic             load_en;
    logic             xfer;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] out_data_d,  out_data_q;
    logic [SEL_W-1:0] out_ch_d,    out_ch_q;
    logic [SEL_W-1:0] ptr_d,       ptr_q;

    // First requester at or after ptr, wrapping; ptr is always below N_CH so one subtract suffices.
    function automatic logic [N_CH-1:0] rr_grant(input logic [N_CH-1:0] req,
                                                 input logic [SEL_W-1:0] ptr);
        logic [N_CH-1:0] g;
        logic [SEL_W:0]  sum;
        logic [SEL_W-1:0] idx;
        logic            done;
        g    = '0;
        done = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            sum = {1'b0, ptr} + (SEL_W+1)'(k);
            if (sum >= (SEL_W+1)'(N_CH)) sum = sum - (SEL_W+1)'(N_CH);
            idx = sum[SEL_W-1:0];
            if (!done && req[idx]) begin
                g[idx] = 1'b1;
                done   = 1'b1;
            end
        end
        return g;
    endfunction

    // NOTE: every combinational output gets a default first, so no path leaves a latch behind.
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        grant_data = '0;
        if (!mode_i) begin
            grant = rr_grant(bus.in_valid, ptr_q);
        end else begin
            // Out-of-range sel matches no channel and so grants nothing.
            for (int i = 0; i < N_CH; i++)
                if (sel_i == SEL_W'(i)) grant[i] = bus.in_valid[i];
        end
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                grant_idx  = SEL_W'(i);
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        load_en     = !out_valid_q || bus.out_ready;
        ready       = rst_n ? (grant & {N_CH{load_en}}) : '0;
        xfer        = |ready;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = grant_data;
                out_ch_d   = grant_idx;
                if (!mode_i)
                    ptr_d = (grant_idx == SEL_W'(N_CH-1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr (N_CH=4, WIDTH=8): vector table of per-cycle inputs and expected grants,
// with a scoreboard of expected output words; reset cases are hand-written sequences.
module tb_stream_mux_rr;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_rdy;
    } row_t;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
    } word_t;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic [1:0] sel;

    int total;
    int bad;

    row_t  rows[25];
    word_t sb[$];

    stream_mux_rr_if #(.N_CH(N_CH), .WIDTH(WIDTH)) bus ();

    stream_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mode_i (mode),
        .sel_i  (sel),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required finish before 100000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic row_t mk(input logic m, input logic [1:0] s, input logic [3:0] v,
                                input logic r, input logic [3:0] e);
        row_t x;
        x.mode = m; x.sel = s; x.valid = v; x.ordy = r; x.exp_rdy = e;
        return x;
    endfunction

    // One cycle: drive at negedge, check 1ns later, the register loads at the following posedge.
    task automatic step(input row_t r);
        word_t w;
        @(negedge clk);
        mode          = r.mode;
        sel           = r.sel;
        bus.in_valid  = r.valid;
        bus.out_ready = r.ordy;
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(r.exp_rdy));
        check("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("out_ch", 32'(bus.out_ch), 32'(sb[0].ch));
            check("out_data", 32'(bus.out_data), 32'(sb[0].data));
            if (r.ordy) void'(sb.pop_front());
        end
        for (int i = 0; i < N_CH; i++) begin
            if (r.exp_rdy[i]) begin
                w.ch   = 2'(i);
                w.data = 8'hA0 + 8'(i);
                sb.push_back(w);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Round-robin fairness from reset, pointer starts at ch0.
        rows[0]  = mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0001);
        rows[1]  = mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0010);
        rows[2]  = mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100);
        rows[3]  = mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b1000);
        rows[4]  = mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0001);
        // Move ptr to 2, then ch1/ch3 only: skip and wrap.
        rows[5]  = mk(1'b0, 2'd0, 4'b0010, 1'b1, 4'b0010);
        rows[6]  = mk(1'b0, 2'd0, 4'b1010, 1'b1, 4'b1000);
        rows[7]  = mk(1'b0, 2'd0, 4'b1010, 1'b1, 4'b0010);
        rows[8]  = mk(1'b0, 2'd0, 4'b1010, 1'b1, 4'b1000);
        // Fixed select ch2, then sel=3 with ch3 idle; ptr must still be 0 afterwards.
        rows[9]  = mk(1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100);
        rows[10] = mk(1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100);
        rows[11] = mk(1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100);
        rows[12] = mk(1'b1, 2'd3, 4'b0111, 1'b1, 4'b0000);
        rows[13] = mk(1'b0, 2'd3, 4'b1111, 1'b1, 4'b0001);
        // Backpressure for three cycles, then drain and load in the same cycle.
        rows[14] = mk(1'b0, 2'd0, 4'b1111, 1'b1, 4'b0010);
        rows[15] = mk(1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000);
        rows[16] = mk(1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000);
        rows[17] = mk(1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000);
        rows[18] = mk(1'b0, 2'd0, 4'b1111, 1'b1, 4'b0100);
        rows[19] = mk(1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000);
        // Empty register loads even with out_ready low; full one does not.
        rows[20] = mk(1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001);
        rows[21] = mk(1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000);
        rows[22] = mk(1'b0, 2'd0, 4'b1111, 1'b1, 4'b0010);
        rows[23] = mk(1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000);
        // Leaves ptr at 3 so the mid-stream reset has something to clear.
        rows[24] = mk(1'b0, 2'd0, 4'b1111, 1'b1, 4'b0100);

        rst_n         = 1'b0;
        mode          = 1'b0;
        sel           = 2'd0;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        bus.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // Held in reset with every channel requesting.
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_ch", 32'(bus.out_ch), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 4'b0000;
        rst_n        = 1'b1;

        for (int i = 0; i < 25; i++) step(rows[i]);

        // Asynchronous reset between edges discards the held word at once.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("async_rst_out_data", 32'(bus.out_data), 32'd0);
        sb.delete();
        bus.in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        // Arbitration restarts at ch0 rather than ch3.
        step(mk(1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001));
        step(mk(1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000));
        step(mk(1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
